// File: rtl/vga_ctrl.sv
// VGA 640x480@60 timing generator with a registered pixel output stage.
// Counters advance once per pixel tick; sync, blank and colour follow one pixel later.
module vga_ctrl #(
  parameter int PIX_DIV = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        inWelcome,
  input  logic [23:0] rgb_welcome,
  input  logic [23:0] rgb_game,
  output logic [9:0]  h_addr,
  output logic [9:0]  v_addr,
  output logic        valid,
  output logic        frame_start,
  output logic        vga_clk,
  output logic        vga_hs,
  output logic        vga_vs,
  output logic        vga_blank_n,
  output logic        vga_sync_n,
  output logic [7:0]  vga_r,
  output logic [7:0]  vga_g,
  output logic [7:0]  vga_b
);

  localparam int DIV_W = $clog2(PIX_DIV);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(PIX_DIV - 1);
  localparam logic [DIV_W-1:0] DIV_HALF = DIV_W'(PIX_DIV / 2);
  localparam logic [DIV_W-1:0] DIV_ONE  = DIV_W'(1);

  localparam logic [9:0] H_ACTIVE     = 10'd640;
  localparam logic [9:0] H_SYNC_START = 10'd656;
  localparam logic [9:0] H_SYNC_END   = 10'd751;
  localparam logic [9:0] H_LAST       = 10'd799;
  localparam logic [9:0] V_ACTIVE     = 10'd480;
  localparam logic [9:0] V_SYNC_START = 10'd490;
  localparam logic [9:0] V_SYNC_END   = 10'd491;
  localparam logic [9:0] V_LAST       = 10'd524;

  logic [DIV_W-1:0] div_q, div_d;
  logic [9:0]       h_q, h_d, v_q, v_d;
  logic             vga_clk_q, vga_clk_d;
  logic             hs_q, hs_d, vs_q, vs_d;
  logic             blank_n_q, blank_n_d;
  logic             fs_q, fs_d;
  logic [23:0]      rgb_q, rgb_d;
  logic             tick;
  logic             active;

  assign tick   = (div_q == DIV_LAST);
  assign active = (h_q < H_ACTIVE) && (v_q < V_ACTIVE);

  always_comb begin
    div_d     = tick ? '0 : div_q + DIV_ONE;
    h_d       = h_q;
    v_d       = v_q;
    hs_d      = hs_q;
    vs_d      = vs_q;
    blank_n_d = blank_n_q;
    rgb_d     = rgb_q;
    fs_d      = 1'b0;
    if (tick) begin
      if (h_q == H_LAST) begin
        h_d = '0;
        v_d = (v_q == V_LAST) ? 10'd0 : v_q + 10'd1;
      end else begin
        h_d = h_q + 10'd1;
      end
      // Output stage captures the position being left, so pins lag the counters by one pixel.
      hs_d      = !((h_q >= H_SYNC_START) && (h_q <= H_SYNC_END));
      vs_d      = !((v_q >= V_SYNC_START) && (v_q <= V_SYNC_END));
      blank_n_d = active;
      rgb_d     = active ? (inWelcome ? rgb_welcome : rgb_game) : 24'h0;
      fs_d      = (h_q == H_LAST) && (v_q == V_LAST);
    end
    vga_clk_d = (div_d >= DIV_HALF);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      div_q     <= '0;
      h_q       <= '0;
      v_q       <= '0;
      vga_clk_q <= 1'b0;
      hs_q      <= 1'b1;
      vs_q      <= 1'b1;
      blank_n_q <= 1'b0;
      rgb_q     <= 24'h0;
      fs_q      <= 1'b0;
    end else begin
      div_q     <= div_d;
      h_q       <= h_d;
      v_q       <= v_d;
      vga_clk_q <= vga_clk_d;
      hs_q      <= hs_d;
      vs_q      <= vs_d;
      blank_n_q <= blank_n_d;
      rgb_q     <= rgb_d;
      fs_q      <= fs_d;
    end
  end

  assign h_addr      = h_q;
  assign v_addr      = v_q;
  assign valid       = active;
  assign frame_start = fs_q;
  assign vga_clk     = vga_clk_q;
  assign vga_hs      = hs_q;
  assign vga_vs      = vs_q;
  assign vga_blank_n = blank_n_q;
  assign vga_sync_n  = 1'b0;
  assign vga_r       = rgb_q[23:16];
  assign vga_g       = rgb_q[15:8];
  assign vga_b       = rgb_q[7:0];

endmodule
